// File: rtl/lr_shift_pipe.sv
// Pipelined left/right shifter: logical, arithmetic and rotate modes on a valid/ready stream.
// Latency: a beat accepted at clock edge t appears on oBits/oValid after edge t+L (L = clog2(width)).
// Backpressure: stall = oValid && !oReady freezes every rank; iReady = !stall && !rst.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   iBits, shift    input word and shift amount (L bits)
//   dir, mode       ShiftDir (0 Left, 1 Right); mode 0 logical, 1 arithmetic, 2 rotate, 3 as logical
//   iValid, iReady  input handshake
//   oBits, oValid   shifted word and output valid
//   oReady          output handshake

package lr_shift_pipe_pkg;

   typedef enum logic {
      Left  = 1'b0,
      Right = 1'b1
   } ShiftDir;

   typedef enum logic [1:0] {
      MODE_LOGIC  = 2'd0,
      MODE_ARITH  = 2'd1,
      MODE_ROTATE = 2'd2,
      MODE_RSVD   = 2'd3
   } shift_mode_e;

endpackage

module lr_shift_pipe
   import lr_shift_pipe_pkg::*;
#(
   parameter int width = 8,
   localparam int L = $clog2(width)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [width-1:0] iBits,
   input  logic [L-1:0]     shift,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic             iValid,
   output logic             iReady,
   output logic [width-1:0] oBits,
   output logic             oValid,
   input  logic             oReady
);

   // Rank 0 captures the accepted beat untouched; rank k+1 holds the result of
   // log-shifter stage k (shift by 2^k when bit k of the captured amount is set).
   localparam int DEPTH = L + 1;

   typedef struct packed {
      logic             vld;
      logic [width-1:0] dat;
      logic [L-1:0]     shf;
      ShiftDir          dir;
      shift_mode_e      mode;
      logic             fill;
   } stage_t;

   stage_t rank_q [DEPTH];
   stage_t rank_d [DEPTH];

   logic stall;
   logic accept;
   logic fill_in;

   assign stall  = rank_q[L].vld && !oReady;
   assign iReady = !stall && !rst;
   assign accept = iValid && iReady;

   // Only an arithmetic right shift drags the sign bit in; every other case
   // vacates with zeros, and rotate never looks at the fill bit at all.
   assign fill_in = (shift_mode_e'(mode) == MODE_ARITH) &&
                    (ShiftDir'(dir) == Right) &&
                    iBits[width-1];

   always_comb begin
      rank_d[0].vld  = accept;
      rank_d[0].dat  = iBits;
      rank_d[0].shf  = shift;
      rank_d[0].dir  = ShiftDir'(dir);
      rank_d[0].mode = shift_mode_e'(mode);
      rank_d[0].fill = fill_in;
   end

   // Each stage shifts by a constant 2^k, which is always below width because
   // L = clog2(width). Composing the stages therefore gives:
   //   - logical/arith-left: bits pushed past the end are lost, so any total
   //     shift >= width leaves all zeros;
   //   - arith-right: vacated positions keep receiving the fill bit, so an
   //     out-of-range shift saturates to all fill bits;
   //   - rotate: each stage is an exact rotation, so the total is shift mod width.
   for (genvar k = 0; k < L; k++) begin : g_stage
      localparam int A = 1 << k;

      logic [width-1:0] d;
      logic [width-1:0] lsh;
      logic [width-1:0] rsh;

      always_comb begin
         d   = rank_q[k].dat;
         lsh = d << A;
         rsh = d >> A;
         if (rank_q[k].mode == MODE_ROTATE) begin
            lsh = lsh | (d >> (width - A));
            rsh = rsh | (d << (width - A));
         end else if (rank_q[k].fill) begin
            rsh = rsh | ~({width{1'b1}} >> A);
         end

         rank_d[k+1] = rank_q[k];
         if (rank_q[k].shf[k]) begin
            rank_d[k+1].dat = (rank_q[k].dir == Right) ? rsh : lsh;
         end
      end
   end

   // Global advance: bubbles move with the valid beats, and nothing moves while
   // the output is held by the consumer.
   always_ff @(posedge clk) begin
      if (rst) begin
         rank_q <= '{default: '0};
      end else if (!stall) begin
         rank_q <= rank_d;
      end
   end

   assign oValid = rank_q[L].vld;
   assign oBits  = rank_q[L].dat;

   // A held beat must stay valid and unchanged until it is taken.
   a_hold_when_stalled : assert property (
      @(posedge clk) disable iff (rst)
      (oValid && !oReady) |=> (oValid && $stable(oBits))
   );

endmodule

// File: tb/tb_lr_shift_pipe.sv
// Testbench for lr_shift_pipe: width=8 and width=6 instances checked against a
// behavioural shift model and an in-order queue scoreboard.
module tb_lr_shift_pipe;
   import lr_shift_pipe_pkg::*;

   localparam int W8 = 8;
   localparam int L8 = 3;
   localparam int W6 = 6;
   localparam int L6 = 3;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   logic [W8-1:0] b8_in, ob8;
   logic [L8-1:0] sh8;
   logic          dir8, iv8, ir8, ov8, or8;
   logic [1:0]    mode8;

   logic [W6-1:0] b6_in, ob6;
   logic [L6-1:0] sh6;
   logic          dir6, iv6, ir6, ov6, or6;
   logic [1:0]    mode6;

   int checks = 0;
   int errors = 0;

   lr_shift_pipe #(.width(W8)) u8 (
      .clk(clk), .rst(rst), .iBits(b8_in), .shift(sh8), .dir(dir8), .mode(mode8),
      .iValid(iv8), .iReady(ir8), .oBits(ob8), .oValid(ov8), .oReady(or8)
   );

   lr_shift_pipe #(.width(W6)) u6 (
      .clk(clk), .rst(rst), .iBits(b6_in), .shift(sh6), .dir(dir6), .mode(mode6),
      .iValid(iv6), .iReady(ir6), .oBits(ob6), .oValid(ov6), .oReady(or6)
   );

   // Reference: shift rules stated directly as word arithmetic on a w-bit value.
   function automatic logic [63:0] ref_shift(input logic [63:0] bits, input int sh,
                                             input logic right, input int mode, input int w);
      logic [63:0]        mask;
      logic signed [63:0] sv;
      int                 s;
      mask = (64'd1 << w) - 64'd1;
      if (mode == 2) begin
         s = sh % w;
         if (s == 0) return bits;
         if (!right) return ((bits << s) | (bits >> (w - s))) & mask;
         return ((bits >> s) | (bits << (w - s))) & mask;
      end
      if (!right) return (bits << sh) & mask;
      if (mode == 1 && ((bits >> (w - 1)) & 64'd1) != 64'd0) begin
         sv = $signed(bits | ~mask);
         return $unsigned(sv >>> sh) & mask;
      end
      return (bits >> sh) & mask;
   endfunction

   task automatic test_reset;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         iv8 = 1'b1; b8_in = 8'($urandom); sh8 = 3'($urandom); dir8 = 1'($urandom);
         mode8 = 2'($urandom); or8 = 1'($urandom);
         iv6 = 1'b1; b6_in = 6'($urandom); sh6 = 3'($urandom); dir6 = 1'($urandom);
         mode6 = 2'($urandom); or6 = 1'($urandom);
         #1;
         checks++;
         if (ov8 !== 1'b0 || ob8 !== 8'h00 || ir8 !== 1'b0) begin
            errors++;
            $display("FAIL reset8: oValid=%b oBits=%h iReady=%b want 0 00 0", ov8, ob8, ir8);
         end
         checks++;
         if (ov6 !== 1'b0 || ob6 !== 6'h00 || ir6 !== 1'b0) begin
            errors++;
            $display("FAIL reset6: oValid=%b oBits=%h iReady=%b want 0 00 0", ov6, ob6, ir6);
         end
      end
      @(negedge clk);
      rst = 1'b0; iv8 = 1'b0; iv6 = 1'b0; or8 = 1'b1; or6 = 1'b1;
      #1;
      checks++;
      if (ir8 !== 1'b1 || ir6 !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: iReady8=%b iReady6=%b want 1 1", ir8, ir6);
      end
   endtask

   task automatic test_directed8;
      logic [7:0] t_bits [9] = '{8'h96, 8'h96, 8'h96, 8'h96, 8'h96, 8'h96, 8'h96, 8'h96, 8'h4C};
      logic [2:0] t_sh   [9] = '{3'd3,  3'd2,  3'd2,  3'd3,  3'd2,  3'd0,  3'd1,  3'd3,  3'd2};
      logic       t_dir  [9] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1};
      logic [1:0] t_mode [9] = '{2'd0,  2'd1,  2'd0,  2'd2,  2'd3,  2'd2,  2'd1,  2'd2,  2'd1};
      logic [7:0] t_exp  [9] = '{8'hB0, 8'hE5, 8'h25, 8'hD2, 8'h25, 8'h96, 8'h2C, 8'hB4, 8'h13};
      for (int v = 0; v < 9; v++) begin
         @(negedge clk);
         b8_in = t_bits[v]; sh8 = t_sh[v]; dir8 = t_dir[v]; mode8 = t_mode[v];
         iv8 = 1'b1; or8 = 1'b1;
         #1;
         checks++;
         if (ir8 !== 1'b1) begin
            errors++;
            $display("FAIL dir8_ready[%0d]: iReady=%b want 1", v, ir8);
         end
         @(posedge clk);
         for (int c = 0; c <= L8; c++) begin
            @(negedge clk);
            if (c == 0) iv8 = 1'b0;
            checks++;
            if (c < L8) begin
               if (ov8 !== 1'b0) begin
                  errors++;
                  $display("FAIL dir8_early[%0d] edge+%0d: oValid=%b want 0", v, c, ov8);
               end
            end else if (ov8 !== 1'b1 || ob8 !== t_exp[v]) begin
               errors++;
               $display("FAIL dir8_result[%0d]: oValid=%b oBits=%h want 1 %h", v, ov8, ob8, t_exp[v]);
            end
         end
      end
   endtask

   task automatic test_width6;
      logic [5:0] t_bits [9] = '{6'h01, 6'h01, 6'h20, 6'h01, 6'h20, 6'h20, 6'h1F, 6'h15, 6'h2D};
      logic [2:0] t_sh   [9] = '{3'd7,  3'd6,  3'd7,  3'd7,  3'd5,  3'd6,  3'd6,  3'd4,  3'd6};
      logic       t_dir  [9] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0};
      logic [1:0] t_mode [9] = '{2'd2,  2'd0,  2'd1,  2'd2,  2'd0,  2'd1,  2'd1,  2'd1,  2'd2};
      logic [5:0] t_exp  [9] = '{6'h02, 6'h00, 6'h3F, 6'h20, 6'h01, 6'h3F, 6'h00, 6'h10, 6'h2D};
      for (int v = 0; v < 9; v++) begin
         @(negedge clk);
         b6_in = t_bits[v]; sh6 = t_sh[v]; dir6 = t_dir[v]; mode6 = t_mode[v];
         iv6 = 1'b1; or6 = 1'b1;
         @(posedge clk);
         for (int c = 0; c <= L6; c++) begin
            @(negedge clk);
            if (c == 0) iv6 = 1'b0;
            checks++;
            if (c < L6) begin
               if (ov6 !== 1'b0) begin
                  errors++;
                  $display("FAIL w6_early[%0d] edge+%0d: oValid=%b want 0", v, c, ov6);
               end
            end else if (ov6 !== 1'b1 || ob6 !== t_exp[v]) begin
               errors++;
               $display("FAIL w6_result[%0d]: oValid=%b oBits=%h want 1 %h", v, ov6, ob6, t_exp[v]);
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] t_bits [6] = '{8'h01, 8'h02, 8'h80, 8'hFF, 8'h96, 8'h7F};
      logic [2:0] t_sh   [6] = '{3'd1,  3'd7,  3'd7,  3'd4,  3'd5,  3'd0};
      logic       t_dir  [6] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0};
      logic [1:0] t_mode [6] = '{2'd0,  2'd2,  2'd1,  2'd0,  2'd2,  2'd1};
      logic [7:0] q [$];
      logic [7:0] exp_v;
      logic [7:0] prev_ob = 8'h00;
      logic       prev_stall = 1'b0;
      int idx = 0;
      int got = 0;
      for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
         @(negedge clk);
         if (prev_stall) begin
            checks++;
            if (ov8 !== 1'b1 || ob8 !== prev_ob) begin
               errors++;
               $display("FAIL b2b_hold cyc%0d: oValid=%b oBits=%h want 1 %h", cyc, ov8, ob8, prev_ob);
            end
         end
         or8 = !(cyc >= 4 && cyc < 9);
         if (idx < 6) begin
            b8_in = t_bits[idx]; sh8 = t_sh[idx]; dir8 = t_dir[idx]; mode8 = t_mode[idx];
            iv8 = 1'b1;
         end else begin
            iv8 = 1'b0;
         end
         #1;
         checks++;
         if (ir8 !== !(ov8 && !or8)) begin
            errors++;
            $display("FAIL b2b_iready cyc%0d: iReady=%b want %b", cyc, ir8, !(ov8 && !or8));
         end
         if (iv8 && ir8) begin
            q.push_back(8'(ref_shift(64'(b8_in), int'(sh8), dir8, int'(mode8), W8)));
            idx++;
         end
         if (ov8 && or8) begin
            checks++;
            exp_v = (q.size() > 0) ? q.pop_front() : 8'hxx;
            if (ob8 !== exp_v) begin
               errors++;
               $display("FAIL b2b_data beat%0d: oBits=%h want %h", got, ob8, exp_v);
            end
            got++;
         end
         prev_stall = ov8 && !or8;
         prev_ob = ob8;
      end
      checks++;
      if (got != 6 || idx != 6 || q.size() != 0) begin
         errors++;
         $display("FAIL b2b_count: sent %0d received %0d pending %0d want 6 6 0", idx, got, q.size());
      end
      iv8 = 1'b0; or8 = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (ov8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_dup cyc%0d: oValid=%b oBits=%h want 0", c, ov8, ob8);
         end
      end
   endtask

   task automatic test_random8;
      logic [7:0] q [$];
      logic [7:0] exp_v;
      logic [7:0] prev_ob = 8'h00;
      logic       prev_stall = 1'b0;
      int sent = 0;
      int got = 0;
      for (int cyc = 0; cyc < 430; cyc++) begin
         @(negedge clk);
         if (prev_stall) begin
            checks++;
            if (ov8 !== 1'b1 || ob8 !== prev_ob) begin
               errors++;
               $display("FAIL rnd8_hold cyc%0d: oValid=%b oBits=%h want 1 %h", cyc, ov8, ob8, prev_ob);
            end
         end
         b8_in = 8'($urandom); sh8 = 3'($urandom); dir8 = 1'($urandom); mode8 = 2'($urandom);
         iv8 = (cyc < 400) && ($urandom_range(3) != 0);
         or8 = (cyc >= 400) || ($urandom_range(9) < 7);
         #1;
         checks++;
         if (ir8 !== !(ov8 && !or8)) begin
            errors++;
            $display("FAIL rnd8_iready cyc%0d: iReady=%b want %b", cyc, ir8, !(ov8 && !or8));
         end
         if (iv8 && ir8) begin
            q.push_back(8'(ref_shift(64'(b8_in), int'(sh8), dir8, int'(mode8), W8)));
            sent++;
         end
         if (ov8 && or8) begin
            checks++;
            exp_v = (q.size() > 0) ? q.pop_front() : 8'hxx;
            if (ob8 !== exp_v) begin
               errors++;
               $display("FAIL rnd8_data beat%0d: oBits=%h want %h", got, ob8, exp_v);
            end
            got++;
         end
         prev_stall = ov8 && !or8;
         prev_ob = ob8;
      end
      iv8 = 1'b0;
      checks++;
      if (q.size() != 0 || got != sent) begin
         errors++;
         $display("FAIL rnd8_count: sent %0d received %0d pending %0d", sent, got, q.size());
      end
   endtask

   task automatic test_random6;
      logic [5:0] q [$];
      logic [5:0] exp_v;
      int sent = 0;
      int got = 0;
      for (int cyc = 0; cyc < 130; cyc++) begin
         @(negedge clk);
         b6_in = 6'($urandom); sh6 = 3'($urandom); dir6 = 1'($urandom); mode6 = 2'($urandom);
         iv6 = (cyc < 120);
         or6 = (cyc >= 120) || ($urandom_range(4) != 0);
         #1;
         if (iv6 && ir6) begin
            q.push_back(6'(ref_shift(64'(b6_in), int'(sh6), dir6, int'(mode6), W6)));
            sent++;
         end
         if (ov6 && or6) begin
            checks++;
            exp_v = (q.size() > 0) ? q.pop_front() : 6'hxx;
            if (ob6 !== exp_v) begin
               errors++;
               $display("FAIL rnd6_data beat%0d: oBits=%h want %h", got, ob6, exp_v);
            end
            got++;
         end
      end
      iv6 = 1'b0;
      checks++;
      if (q.size() != 0 || got != sent) begin
         errors++;
         $display("FAIL rnd6_count: sent %0d received %0d pending %0d", sent, got, q.size());
      end
   endtask

   task automatic test_reset_mid;
      or8 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         b8_in = 8'($urandom); sh8 = 3'($urandom); dir8 = 1'($urandom); mode8 = 2'($urandom);
         iv8 = 1'b1;
         #1;
         checks++;
         if (ir8 !== 1'b1) begin
            errors++;
            $display("FAIL rmid_accept[%0d]: iReady=%b want 1", i, ir8);
         end
      end
      // First beat would become visible after the next edge; reset lands on it.
      @(negedge clk);
      iv8 = 1'b0; rst = 1'b1;
      #1;
      checks++;
      if (ov8 !== 1'b0 || ir8 !== 1'b0) begin
         errors++;
         $display("FAIL rmid_pre: oValid=%b iReady=%b want 0 0", ov8, ir8);
      end
      @(negedge clk);
      checks++;
      if (ov8 !== 1'b0 || ob8 !== 8'h00) begin
         errors++;
         $display("FAIL rmid_cleared: oValid=%b oBits=%h want 0 00", ov8, ob8);
      end
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if (ov8 !== 1'b0) begin
            errors++;
            $display("FAIL rmid_leak cyc%0d: oValid=%b oBits=%h want 0", c, ov8, ob8);
         end
      end
      @(negedge clk);
      b8_in = 8'h96; sh8 = 3'd2; dir8 = Right; mode8 = 2'd1; iv8 = 1'b1;
      @(posedge clk);
      for (int c = 0; c <= L8; c++) begin
         @(negedge clk);
         if (c == 0) iv8 = 1'b0;
         checks++;
         if (c < L8) begin
            if (ov8 !== 1'b0) begin
               errors++;
               $display("FAIL rmid_early edge+%0d: oValid=%b want 0", c, ov8);
            end
         end else if (ov8 !== 1'b1 || ob8 !== 8'hE5) begin
            errors++;
            $display("FAIL rmid_result: oValid=%b oBits=%h want 1 e5", ov8, ob8);
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      b8_in = '0; sh8 = '0; dir8 = 1'b0; mode8 = '0; iv8 = 1'b0; or8 = 1'b1;
      b6_in = '0; sh6 = '0; dir6 = 1'b0; mode6 = '0; iv6 = 1'b0; or6 = 1'b1;
      test_reset;
      test_directed8;
      test_width6;
      test_back_to_back;
      test_random8;
      test_random6;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
